// File: rtl/div_pkg.sv
// Shared encodings for the iterative RV32M divider: op codes, FSM states and small helpers.
package div_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_CALC  = 2'b01;
    localparam logic [1:0] S_FIXUP = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    function automatic int cnt_width(input int xlen);
        return (xlen <= 2) ? 1 : $clog2(xlen);
    endfunction

    // op[0] clear means the signed variant, op[1] set means the remainder is returned
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
interface div_unit_if #(parameter int XLEN = 32);

    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            div_by_zero;

    modport master (output start, op, a, b, input busy, done, result, div_by_zero);
    modport slave  (input start, op, a, b, output busy, done, result, div_by_zero);

endinterface

// File: rtl/div_step.sv
// One restoring division iteration: shift rem:quo left, trial-subtract the divisor, keep or restore.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN:0]   i_div,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    // The partial remainder is always below the divisor, so XLEN+1 bits hold the shifted value
    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_diff  = w_shift - i_div;
    assign o_rem   = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
    assign o_quo   = {i_quo[XLEN-2:0], ~w_diff[XLEN]};

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Define DIV_FAST_SPECIAL_EN to finish divide-by-zero and signed overflow straight from IDLE.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    div_unit_if.slave bus
);
    import div_pkg::*;

    localparam int CNT_W = cnt_width(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      r_state;
    logic [1:0]      r_op;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN:0]   r_div;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic            r_negq;
    logic            r_negr;
    logic            r_bzero;
    logic            r_ovf;
    logic            r_dbz;

    logic            w_accept;
    logic            w_a_neg;
    logic            w_b_neg;
    logic            w_bzero;
    logic            w_ovf;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic [XLEN-1:0] w_final;

    // RISC-V mandated results that override whatever the iteration produced
    function automatic logic [XLEN-1:0] special_value(input logic [1:0] op,
                                                      input logic bz,
                                                      input logic [XLEN-1:0] a);
        if (bz)
            return op_is_rem(op) ? a : {XLEN{1'b1}};
        return op_is_rem(op) ? {XLEN{1'b0}} : MIN_INT;
    endfunction

    assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_a_neg  = op_is_signed(bus.op) && bus.a[XLEN-1];
    assign w_b_neg  = op_is_signed(bus.op) && bus.b[XLEN-1];
    assign w_abs_a  = w_a_neg ? -bus.a : bus.a;
    assign w_abs_b  = w_b_neg ? -bus.b : bus.b;
    assign w_bzero  = (bus.b == {XLEN{1'b0}});
    assign w_ovf    = op_is_signed(bus.op) && (bus.a == MIN_INT) && (bus.b == {XLEN{1'b1}});

    div_step #(.XLEN(XLEN)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    assign w_quo_fix = r_negq ? -r_quo : r_quo;
    assign w_rem_fix = r_negr ? -r_rem : r_rem;
    assign w_final   = (r_bzero || r_ovf) ? special_value(r_op, r_bzero, r_a)
                     : (op_is_rem(r_op) ? w_rem_fix : w_quo_fix);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= OP_DIV;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_a      <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_negq   <= 1'b0;
            r_negr   <= 1'b0;
            r_bzero  <= 1'b0;
            r_ovf    <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_op    <= bus.op;
                        r_a     <= bus.a;
                        r_rem   <= '0;
                        r_quo   <= w_abs_a;
                        r_div   <= {1'b0, w_abs_b};
                        r_cnt   <= CNT_W'(XLEN - 1);
                        r_negq  <= w_a_neg ^ w_b_neg;
                        r_negr  <= w_a_neg;
                        r_bzero <= w_bzero;
                        r_ovf   <= w_ovf;
`ifdef DIV_FAST_SPECIAL_EN
                        if (w_bzero || w_ovf) begin
                            r_result <= special_value(bus.op, w_bzero, bus.a);
                            r_dbz    <= w_bzero;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_CALC;
                        end
`else
                        r_state <= S_CALC;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0)
                        r_state <= S_FIXUP;
                end
                S_FIXUP: begin
                    r_result <= w_final;
                    r_dbz    <= r_bzero;
                    r_state  <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = (r_state == S_CALC) || (r_state == S_FIXUP);
    assign bus.done        = (r_state == S_DONE);
    assign bus.result      = r_result;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; latency counts the start-sampling edge as edge 1.
module tb_div_unit;
    import div_pkg::*;

    localparam int XLEN = 32;
    localparam int NORM_LAT = XLEN + 2;
`ifdef DIV_FAST_SPECIAL_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = XLEN + 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    div_unit_if #(.XLEN(XLEN)) bus ();

    div_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Present one request at the negative edge and hold it through exactly one sampling edge
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 1;
        while (bus.done !== 1'b1 && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic dbz);
        applyStimulus(op, a, b);
        waitDone(lat);
        res = bus.result;
        dbz = bus.div_by_zero;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.result !== 32'h0) begin failures++; $display("[TB] FAIL reset_result got=%h exp=00000000", bus.result); end
        checks++; if (bus.div_by_zero !== 1'b0) begin failures++; $display("[TB] FAIL reset_dbz got=%b exp=0", bus.div_by_zero); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_divu();
        int lat;
        logic [31:0] res;
        logic dbz;
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL divu_busy got=%b exp=1", bus.busy); end
        waitDone(lat);
        checks++; if (lat != NORM_LAT) begin failures++; $display("[TB] FAIL divu_latency got=%0d exp=%0d", lat, NORM_LAT); end
        checks++; if (bus.result !== 32'd14) begin failures++; $display("[TB] FAIL divu_result got=%h exp=0000000e", bus.result); end
        checks++; if (bus.div_by_zero !== 1'b0) begin failures++; $display("[TB] FAIL divu_dbz got=%b exp=0", bus.div_by_zero); end
        @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL divu_done_pulse got=%b exp=0", bus.done); end
        checks++; if (bus.result !== 32'd14) begin failures++; $display("[TB] FAIL divu_hold got=%h exp=0000000e", bus.result); end
        runOp(OP_REMU, 32'd100, 32'd7, lat, res, dbz);
        checks++; if (res !== 32'd2) begin failures++; $display("[TB] FAIL remu_result got=%h exp=00000002", res); end
        runOp(OP_DIVU, 32'hFFFF_FFEC, 32'd3, lat, res, dbz);
        checks++; if (res !== 32'h5555_554E) begin failures++; $display("[TB] FAIL divu_big got=%h exp=5555554e", res); end
    endtask

    task automatic test_signed();
        int lat;
        logic [31:0] res;
        logic dbz;
        runOp(OP_DIV, 32'hFFFF_FFEC, 32'd3, lat, res, dbz);
        checks++; if (res !== 32'hFFFF_FFFA) begin failures++; $display("[TB] FAIL div_neg got=%h exp=fffffffa", res); end
        checks++; if (lat != NORM_LAT) begin failures++; $display("[TB] FAIL div_latency got=%0d exp=%0d", lat, NORM_LAT); end
        runOp(OP_REM, 32'hFFFF_FFF9, 32'd2, lat, res, dbz);
        checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL rem_neg got=%h exp=ffffffff", res); end
        runOp(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, res, dbz);
        checks++; if (res !== 32'hFFFF_FFFD) begin failures++; $display("[TB] FAIL div_negb got=%h exp=fffffffd", res); end
        runOp(OP_REM, 32'd7, 32'hFFFF_FFFE, lat, res, dbz);
        checks++; if (res !== 32'd1) begin failures++; $display("[TB] FAIL rem_negb got=%h exp=00000001", res); end
    endtask

    task automatic test_div_by_zero();
        int lat;
        logic [31:0] res;
        logic dbz;
        runOp(OP_DIV, 32'd5, 32'd0, lat, res, dbz);
        checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL dz_div got=%h exp=ffffffff", res); end
        checks++; if (dbz !== 1'b1) begin failures++; $display("[TB] FAIL dz_div_flag got=%b exp=1", dbz); end
        checks++; if (lat != SPEC_LAT) begin failures++; $display("[TB] FAIL dz_latency got=%0d exp=%0d", lat, SPEC_LAT); end
        runOp(OP_REMU, 32'd5, 32'd0, lat, res, dbz);
        checks++; if (res !== 32'd5) begin failures++; $display("[TB] FAIL dz_remu got=%h exp=00000005", res); end
        checks++; if (dbz !== 1'b1) begin failures++; $display("[TB] FAIL dz_remu_flag got=%b exp=1", dbz); end
        runOp(OP_REM, 32'hFFFF_FFF9, 32'd0, lat, res, dbz);
        checks++; if (res !== 32'hFFFF_FFF9) begin failures++; $display("[TB] FAIL dz_rem got=%h exp=fffffff9", res); end
        runOp(OP_DIVU, 32'd9, 32'd3, lat, res, dbz);
        checks++; if (dbz !== 1'b0) begin failures++; $display("[TB] FAIL dz_flag_clear got=%b exp=0", dbz); end
    endtask

    task automatic test_overflow();
        int lat;
        logic [31:0] res;
        logic dbz;
        runOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, dbz);
        checks++; if (res !== 32'h8000_0000) begin failures++; $display("[TB] FAIL ovf_div got=%h exp=80000000", res); end
        checks++; if (dbz !== 1'b0) begin failures++; $display("[TB] FAIL ovf_flag got=%b exp=0", dbz); end
        checks++; if (lat != SPEC_LAT) begin failures++; $display("[TB] FAIL ovf_latency got=%0d exp=%0d", lat, SPEC_LAT); end
        runOp(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, dbz);
        checks++; if (res !== 32'h0) begin failures++; $display("[TB] FAIL ovf_rem got=%h exp=00000000", res); end
    endtask

    task automatic test_back_to_back();
        int cycles;
        int lat;
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        cycles = 1;
        while (bus.done !== 1'b1 && cycles < 100) begin
            if (cycles == 5) begin
                @(negedge clk);
                bus.start = 1'b1;
                bus.op    = OP_DIVU;
                bus.a     = 32'd9;
                bus.b     = 32'd3;
                @(posedge clk);
                #1;
                bus.start = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
            cycles++;
        end
        checks++; if (cycles != NORM_LAT) begin failures++; $display("[TB] FAIL b2b_latency got=%0d exp=%0d", cycles, NORM_LAT); end
        checks++; if (bus.result !== 32'd14) begin failures++; $display("[TB] FAIL b2b_ignored got=%h exp=0000000e", bus.result); end
        applyStimulus(OP_DIVU, 32'd9, 32'd3);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_accept_busy got=%b exp=1", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL b2b_single_done got=%b exp=0", bus.done); end
        waitDone(lat);
        checks++; if (lat != NORM_LAT) begin failures++; $display("[TB] FAIL b2b_second_latency got=%0d exp=%0d", lat, NORM_LAT); end
        checks++; if (bus.result !== 32'd3) begin failures++; $display("[TB] FAIL b2b_second_result got=%h exp=00000003", bus.result); end
    endtask

    task automatic test_reset_mid_op();
        int doneSeen;
        applyStimulus(OP_DIV, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL midrst_done got=%b exp=0", bus.done); end
        checks++; if (bus.result !== 32'h0) begin failures++; $display("[TB] FAIL midrst_result got=%h exp=00000000", bus.result); end
        @(negedge clk);
        rst_n = 1'b1;
        doneSeen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) doneSeen++;
        end
        checks++; if (doneSeen != 0) begin failures++; $display("[TB] FAIL midrst_no_done got=%0d exp=0", doneSeen); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = OP_DIV;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_divu();
        test_signed();
        test_div_by_zero();
        test_overflow();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
